// File: rtl/aznable_timer_pkg.sv
// Shared definitions for the timer alarm unit: register map, CTRL bit
// positions, FSM encoding and the CPU bus request bundle.
package aznable_timer_pkg;

    localparam int CNT_W = 16;

    // Register addresses
    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_INT_LO  = 3'd2;
    localparam logic [2:0] ADDR_INT_HI  = 3'd3;
    localparam logic [2:0] ADDR_SNAP_LO = 3'd4;
    localparam logic [2:0] ADDR_SNAP_HI = 3'd5;

    // CTRL bit indices
    localparam int CTRL_EN  = 0;
    localparam int CTRL_PER = 1;
    localparam int CTRL_IRQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        ARMED = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] din;
        logic       wr;
        logic       rd;
    } bus_req_t;

    // An interval of zero would never match again after arming; run it as 1.
    function automatic logic [CNT_W-1:0] eff_interval(input logic [CNT_W-1:0] iv);
        return (iv == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : iv;
    endfunction

endpackage

// File: rtl/timer_alarm_regs.sv
// CPU-facing register block: write decode, CTRL/interval storage,
// registered read mux and the tear-free counter snapshot latch.
module timer_alarm_regs
    import aznable_timer_pkg::*;
#(
    parameter logic [15:0] DEFAULT_INTERVAL = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] counter,
    input  logic [2:0]  addr,
    input  logic [7:0]  din,
    input  logic        wr,
    input  logic        rd,
    input  logic        fired,
    input  logic        clr_enable,
    output logic [7:0]  dout,
    output logic        enable,
    output logic        periodic,
    output logic        irq_en,
    output logic [15:0] interval,
    output logic        ctrl_en_wr,
    output logic        ctrl_dis_wr,
    output logic        inthi_wr,
    output logic        status_clr
);

    bus_req_t   req;
    logic       ctrl_wr;
    logic [7:0] staging;
    logic [7:0] snap;
    logic [7:0] rdata;

    assign req         = '{addr: addr, din: din, wr: wr, rd: rd};
    assign ctrl_wr     = req.wr && (req.addr == ADDR_CTRL);
    assign ctrl_en_wr  = ctrl_wr &&  req.din[CTRL_EN];
    assign ctrl_dis_wr = ctrl_wr && !req.din[CTRL_EN];
    assign inthi_wr    = req.wr && (req.addr == ADDR_INT_HI);
    assign status_clr  = req.wr && (req.addr == ADDR_STATUS) && req.din[0];

    // CTRL register; a one-shot fire drops enable unless the CPU writes CTRL
    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= 1'b0;
            periodic <= 1'b0;
            irq_en   <= 1'b0;
        end else if (ctrl_wr) begin
            enable   <= req.din[CTRL_EN];
            periodic <= req.din[CTRL_PER];
            irq_en   <= req.din[CTRL_IRQ];
        end else if (clr_enable) begin
            enable   <= 1'b0;
        end
    end

    // Interval is written as two bytes; the high byte write commits both
    always_ff @(posedge clk) begin
        if (reset) begin
            staging  <= 8'd0;
            interval <= DEFAULT_INTERVAL;
        end else if (req.wr && (req.addr == ADDR_INT_LO)) begin
            staging  <= req.din;
        end else if (inthi_wr) begin
            interval <= {req.din, staging};
        end
    end

    // Read mux; INT_LO/INT_HI read back the staged byte and committed high byte
    always_comb begin
        rdata = 8'd0;
        case (req.addr)
            ADDR_CTRL:    rdata = {5'd0, irq_en, periodic, enable};
            ADDR_STATUS:  rdata = {7'd0, fired};
            ADDR_INT_LO:  rdata = staging;
            ADDR_INT_HI:  rdata = interval[15:8];
            ADDR_SNAP_LO: rdata = counter[7:0];
            ADDR_SNAP_HI: rdata = snap;
            default:      rdata = 8'd0;
        endcase
    end

    // Registered read data; reading SNAP_LO freezes the high byte for SNAP_HI
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= 8'd0;
            snap <= 8'd0;
        end else if (req.rd) begin
            dout <= rdata;
            if (req.addr == ADDR_SNAP_LO) snap <= counter[15:8];
        end
    end

endmodule

// File: rtl/timer_alarm.sv
// Alarm/interval unit on top of the free-running tick counter: tick/jump
// detection, arm/compare FSM, fired flag and level IRQ.
module timer_alarm
    import aznable_timer_pkg::*;
#(
    parameter int          COUNTER_WIDTH    = 16,
    parameter logic [15:0] DEFAULT_INTERVAL = 16'd1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [COUNTER_WIDTH-1:0] counter,
    input  logic [2:0]               addr,
    input  logic [7:0]               din,
    input  logic                     wr,
    input  logic                     rd,
    output logic [7:0]               dout,
    output logic                     irq
);

    state_t      state, state_d;
    logic [15:0] prev_counter;
    logic [15:0] deadline, deadline_d;
    logic [15:0] interval, eff;
    logic        enable, periodic, irq_en;
    logic        ctrl_en_wr, ctrl_dis_wr, inthi_wr, status_clr;
    logic        fired, fire, clr_enable;
    logic        tick, jump, restart;

    timer_alarm_regs #(.DEFAULT_INTERVAL(DEFAULT_INTERVAL)) u_regs (
        .clk         (clk),
        .reset       (reset),
        .counter     (counter),
        .addr        (addr),
        .din         (din),
        .wr          (wr),
        .rd          (rd),
        .fired       (fired),
        .clr_enable  (clr_enable),
        .dout        (dout),
        .enable      (enable),
        .periodic    (periodic),
        .irq_en      (irq_en),
        .interval    (interval),
        .ctrl_en_wr  (ctrl_en_wr),
        .ctrl_dis_wr (ctrl_dis_wr),
        .inthi_wr    (inthi_wr),
        .status_clr  (status_clr)
    );

    assign eff  = eff_interval(interval);
    assign tick = (counter == 16'(prev_counter + 16'd1));
    assign jump = (counter != prev_counter) && !tick;

    // Restarts only matter once an alarm is in flight; an INT_HI write in IDLE
    // just updates the interval.
    assign restart = ctrl_en_wr || (inthi_wr && (state != IDLE));

    // Any CTRL or INT_HI write on the match cycle pre-empts the fire: a
    // disable must win, and a restart re-bases the deadline anyway.
    assign fire = (state == ARMED) && tick && (counter == deadline) &&
                  !ctrl_en_wr && !ctrl_dis_wr && !inthi_wr;

    assign clr_enable = fire && !periodic;

    // State and deadline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            deadline <= 16'd0;
        end else begin
            state    <= state_d;
            deadline <= deadline_d;
        end
    end

    // Next-state: disable beats restart beats jump re-arm beats compare
    always_comb begin
        state_d    = state;
        deadline_d = deadline;
        if (ctrl_dis_wr) begin
            state_d = IDLE;
        end else if (restart) begin
            state_d = ARM;
        end else begin
            case (state)
                IDLE: state_d = IDLE;
                ARM: begin
                    state_d    = ARMED;
                    deadline_d = 16'(counter + eff);
                end
                ARMED: begin
                    if (jump) begin
                        state_d = ARM;
                    end else if (fire) begin
                        if (periodic) deadline_d = 16'(deadline + eff);
                        else          state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Fired flag: a fire on the same cycle as a STATUS clear keeps it set
    always_ff @(posedge clk) begin
        if (reset)           fired <= 1'b0;
        else if (fire)       fired <= 1'b1;
        else if (status_clr) fired <= 1'b0;
    end

    // Counter history for tick/jump detection, and registered IRQ level
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_counter <= 16'd0;
            irq          <= 1'b0;
        end else begin
            prev_counter <= counter;
            irq          <= fired && irq_en;
        end
    end

    // Upstream width is fixed by the register map; enable mirrors FSM activity
    // and is only observed through CTRL reads.
    logic unused_ok;
    assign unused_ok = enable;

endmodule

// File: tb/tb_timer_alarm.sv
// Self-checking bench for timer_alarm: directed scenarios plus a random
// phase, every cycle compared against a countdown-based reference model.
module tb_timer_alarm;

    localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_INT_LO = 3'd2,
                           A_INT_HI = 3'd3, A_SNAP_LO = 3'd4, A_SNAP_HI = 3'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] counter;
    logic [2:0]  addr;
    logic [7:0]  din;
    logic        wr, rd;
    logic [7:0]  dout;
    logic        irq;

    int checks = 0;
    int failures = 0;

    timer_alarm dut (
        .clk     (clk),
        .reset   (reset),
        .counter (counter),
        .addr    (addr),
        .din     (din),
        .wr      (wr),
        .rd      (rd),
        .dout    (dout),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: alarm kept as a count of remaining ticks
    bit          m_en, m_per, m_ie, m_fired, m_irq;
    logic [15:0] m_interval = 16'd1000, m_prev = 16'd0;
    logic [7:0]  m_staging = 8'd0, m_snap = 8'd0, m_dout = 8'd0;
    int          m_phase = 0;   // 0 off, 1 arming, 2 counting down
    int          m_rem = 0;

    task automatic model_step();
        logic [15:0] eff;
        logic [7:0]  rdv;
        bit tick, jump, ctrl_w, dis, en_w, ih_w, st_clr, fire;
        if (reset) begin
            m_en = 0; m_per = 0; m_ie = 0; m_fired = 0; m_irq = 0;
            m_interval = 16'd1000; m_prev = 16'd0; m_staging = 8'd0;
            m_snap = 8'd0; m_dout = 8'd0; m_phase = 0; m_rem = 0;
            return;
        end
        eff    = (m_interval == 16'd0) ? 16'd1 : m_interval;
        tick   = (counter == 16'(m_prev + 16'd1));
        jump   = (counter != m_prev) && !tick;
        ctrl_w = wr && (addr == A_CTRL);
        dis    = ctrl_w && !din[0];
        en_w   = ctrl_w && din[0];
        ih_w   = wr && (addr == A_INT_HI);
        st_clr = wr && (addr == A_STATUS) && din[0];
        fire   = 0;
        if (rd) begin
            rdv = 8'd0;
            case (addr)
                A_CTRL:    rdv = {5'd0, m_ie, m_per, m_en};
                A_STATUS:  rdv = {7'd0, m_fired};
                A_INT_LO:  rdv = m_staging;
                A_INT_HI:  rdv = m_interval[15:8];
                A_SNAP_LO: begin rdv = counter[7:0]; m_snap = counter[15:8]; end
                A_SNAP_HI: rdv = m_snap;
                default:   rdv = 8'd0;
            endcase
            m_dout = rdv;
        end
        m_irq  = m_fired & m_ie;
        m_prev = counter;
        if (dis) m_phase = 0;
        else if (en_w || (ih_w && m_phase != 0)) m_phase = 1;
        else if (m_phase == 1) begin m_phase = 2; m_rem = int'(eff); end
        else if (m_phase == 2 && jump) m_phase = 1;
        else if (m_phase == 2 && tick) begin
            if (m_rem == 1) begin
                fire = 1;
                if (m_per) m_rem = int'(eff);
                else begin m_phase = 0; m_en = 0; end
            end else begin
                m_rem--;
            end
        end
        if (ctrl_w) begin m_en = din[0]; m_per = din[1]; m_ie = din[2]; end
        if (fire) m_fired = 1;
        else if (st_clr) m_fired = 0;
        if (wr && addr == A_INT_LO) m_staging = din;
        if (ih_w) m_interval = {din, m_staging};
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("irq", irq, m_irq);
        chk("dout", dout, m_dout);
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin counter = counter + 16'd1; step(); end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        addr = a; din = d; wr = 1'b1; step(); wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [7:0] v);
        addr = a; rd = 1'b1; step(); rd = 1'b0; v = dout;
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int r, s;
        reset = 1'b1; counter = 16'd0; addr = 3'd0; din = 8'd0; wr = 1'b0; rd = 1'b0;

        // Reset state
        do_reset();
        chk("rst_irq", irq, 0);
        chk("rst_dout", dout, 0);
        rd_reg(A_CTRL, v);   chk("rst_ctrl", v, 8'h00);
        rd_reg(A_STATUS, v); chk("rst_status", v, 8'h00);

        // One-shot, interval 5 from counter 100
        counter = 16'd100; hold(2);
        wr_reg(A_INT_LO, 8'd5); wr_reg(A_INT_HI, 8'd0); wr_reg(A_CTRL, 8'h01); hold(1);
        ticks(4);
        rd_reg(A_STATUS, v); chk("oneshot_early", v, 8'h00);
        ticks(1);
        rd_reg(A_STATUS, v); chk("oneshot_fired", v, 8'h01);
        rd_reg(A_CTRL, v);   chk("oneshot_ctrl", v, 8'h00);
        chk("oneshot_irq", irq, 0);

        // Periodic with IRQ, interval 3 from counter 10
        do_reset();
        counter = 16'd10; hold(1);
        wr_reg(A_INT_LO, 8'd3); wr_reg(A_INT_HI, 8'd0); wr_reg(A_CTRL, 8'h07); hold(1);
        ticks(3);
        chk("per_irq_lag", irq, 0);
        hold(1);
        chk("per_irq_set", irq, 1);
        rd_reg(A_STATUS, v); chk("per_fire13", v, 8'h01);
        wr_reg(A_STATUS, 8'h01);
        rd_reg(A_STATUS, v); chk("per_clear", v, 8'h00);
        chk("per_irq_clr", irq, 0);
        ticks(3);
        rd_reg(A_STATUS, v); chk("per_fire16", v, 8'h01);
        wr_reg(A_STATUS, 8'h01);
        ticks(3);
        rd_reg(A_STATUS, v); chk("per_fire19", v, 8'h01);

        // Deadline across the 0xFFFF -> 0x0000 wrap
        do_reset();
        counter = 16'hFFFE; hold(1);
        wr_reg(A_INT_LO, 8'd4); wr_reg(A_INT_HI, 8'd0); wr_reg(A_CTRL, 8'h01); hold(1);
        ticks(3);
        rd_reg(A_STATUS, v); chk("wrap_early", v, 8'h00);
        ticks(1);
        rd_reg(A_STATUS, v); chk("wrap_fired", v, 8'h01);

        // Snapshot atomicity
        counter = 16'h12FF;
        rd_reg(A_SNAP_LO, v); chk("snap_lo", v, 8'hFF);
        counter = 16'h1300;
        rd_reg(A_SNAP_HI, v); chk("snap_hi", v, 8'h12);
        rd_reg(3'd6, v);      chk("addr6", v, 8'h00);

        // STATUS clear on the fire cycle keeps fired
        do_reset();
        counter = 16'd50; hold(1);
        wr_reg(A_INT_LO, 8'd2); wr_reg(A_INT_HI, 8'd0); wr_reg(A_CTRL, 8'h01); hold(1);
        ticks(1);
        counter = 16'd52; wr_reg(A_STATUS, 8'h01);
        rd_reg(A_STATUS, v); chk("sim_clr_fire", v, 8'h01);

        // CTRL disable on the fire cycle wins
        wr_reg(A_STATUS, 8'h01);
        counter = 16'd60; hold(1);
        wr_reg(A_CTRL, 8'h03); hold(1);
        ticks(1);
        counter = 16'd62; wr_reg(A_CTRL, 8'h00);
        rd_reg(A_STATUS, v); chk("sim_dis_fire", v, 8'h00);
        rd_reg(A_CTRL, v);   chk("sim_dis_ctrl", v, 8'h00);
        ticks(2);
        rd_reg(A_STATUS, v); chk("sim_dis_idle", v, 8'h00);

        // Counter jump while armed re-arms from the new value
        do_reset();
        counter = 16'd0; hold(1);
        wr_reg(A_INT_LO, 8'hF4); wr_reg(A_INT_HI, 8'h01); wr_reg(A_CTRL, 8'h01); hold(1);
        ticks(300);
        counter = 16'd0; hold(2);
        ticks(499);
        rd_reg(A_STATUS, v); chk("jump_early", v, 8'h00);
        ticks(1);
        rd_reg(A_STATUS, v); chk("jump_fired", v, 8'h01);

        // Reset mid-operation, strobes ignored, interval back to 1000
        do_reset();
        counter = 16'd0; hold(1);
        wr_reg(A_INT_LO, 8'd2); wr_reg(A_INT_HI, 8'd0); wr_reg(A_CTRL, 8'h07); hold(1);
        ticks(2); hold(2);
        chk("mid_irq_pre", irq, 1);
        reset = 1'b1; addr = A_CTRL; din = 8'h07; wr = 1'b1; step();
        reset = 1'b0; wr = 1'b0;
        chk("mid_irq", irq, 0);
        chk("mid_dout", dout, 0);
        rd_reg(A_STATUS, v); chk("mid_status", v, 8'h00);
        rd_reg(A_CTRL, v);   chk("mid_ctrl", v, 8'h00);
        wr_reg(A_CTRL, 8'h01); hold(1);
        ticks(999);
        rd_reg(A_STATUS, v); chk("dflt_early", v, 8'h00);
        ticks(1);
        rd_reg(A_STATUS, v); chk("dflt_fired", v, 8'h01);

        // Random traffic against the model
        do_reset();
        repeat (4000) begin
            r = $urandom_range(0, 99);
            if (r < 50)      counter = counter + 16'd1;
            else if (r < 53) counter = 16'($urandom);
            s = $urandom_range(0, 19);
            addr = 3'($urandom_range(0, 7));
            if (s < 2) begin
                wr = 1'b1;
                if (addr == A_INT_LO)      din = 8'($urandom_range(0, 6));
                else if (addr == A_INT_HI) din = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'd0;
                else                       din = 8'($urandom);
            end else if (s < 5) begin
                rd = 1'b1;
            end
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            step();
            wr = 1'b0; rd = 1'b0; reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
